img2col_round_sched: RTL and testbench

Round scheduler for the img2col mapping stage. Accepts one layer configuration, splits the output rows into rounds of up to NUM_PU rows, and dispatches one row per PU per round over a valid/ready handshake. It advances to the next round only after every PU dispatched in the current round has signalled done, and reports the current round, base row, PU and row indices.

---
 rtl/img2col_round_sched_pkg.sv | 22 ++
 rtl/img2col_round_sched.sv | 159 +++++++++++++++
 tb/tb_img2col_round_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/img2col_round_sched_pkg.sv
// Shared types and helpers for the img2col round scheduler.
//   state_t        : scheduler FSM states
//   ROW_W_DEF      : default width of row/round/index fields
//   calc_out_rows  : output rows produced by a valid (img_rows, kernel) pair
package img2col_round_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int unsigned ROW_W_DEF = 6;

  // Valid only when 1 <= kernel <= img_rows; callers truncate to their field width.
  function automatic int unsigned calc_out_rows(input int unsigned img_rows,
                                                input int unsigned kernel);
    return img_rows - kernel + 1;
  endfunction

endpackage

// File: rtl/img2col_round_sched.sv
// Round scheduler for the img2col mapping stage.
// Accepts one layer configuration, splits the output rows into rounds of up to
// NUM_PU rows and dispatches one row per PU per round over valid/ready. A new
// round starts only once every PU dispatched in the current round reports done.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_valid/cfg_ready           configuration handshake (ready only in IDLE)
//   cfg_img_rows, cfg_kernel      layer geometry
//   cfg_err                       one-cycle pulse on a rejected configuration
//   disp_valid/disp_ready         dispatch handshake
//   disp_pu, disp_row             target PU and output row of the dispatch
//   pu_done                       per-PU one-cycle completion pulses
//   current_round                 round index
//   current_PU1_add               first row of the round (round*NUM_PU)
//   current_PU_No                 PU being dispatched, zero-extended
//   current_row_No                same as disp_row
//   busy                          high whenever not IDLE
//   layer_done                    one-cycle pulse at the end of the layer
module img2col_round_sched
  import img2col_round_sched_pkg::*;
#(
  parameter int unsigned NUM_PU = 4,
  parameter int unsigned ROW_W  = ROW_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ROW_W-1:0]          cfg_img_rows,
  input  logic [2:0]                cfg_kernel,
  output logic                      cfg_err,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [$clog2(NUM_PU)-1:0] disp_pu,
  output logic [ROW_W-1:0]          disp_row,
  input  logic [NUM_PU-1:0]         pu_done,
  output logic [ROW_W-1:0]          current_round,
  output logic [ROW_W-1:0]          current_PU1_add,
  output logic [ROW_W-1:0]          current_PU_No,
  output logic [ROW_W-1:0]          current_row_No,
  output logic                      busy,
  output logic                      layer_done
);

  localparam int unsigned PU_W = $clog2(NUM_PU);

  state_t              state;
  logic [ROW_W-1:0]    round_q;
  logic [ROW_W-1:0]    row_q;
  logic [PU_W-1:0]     pu_q;
  logic [ROW_W-1:0]    out_rows_q;
  logic [ROW_W-1:0]    last_round_q;
  logic [NUM_PU-1:0]   pending_q;

  logic                cfg_bad;
  logic [ROW_W-1:0]    cfg_out_rows;
  logic                disp_fire;
  logic                round_end;
  logic [NUM_PU-1:0]   dispatch_set;
  logic [NUM_PU-1:0]   pending_left;

  // Configuration validation and derived row count
  assign cfg_bad      = (cfg_kernel == 3'd0) || (cfg_img_rows == '0) ||
                        (32'(cfg_kernel) > 32'(cfg_img_rows));
  assign cfg_out_rows = ROW_W'(calc_out_rows(32'(cfg_img_rows), 32'(cfg_kernel)));

  // Pending tracker: done pulses clear, accepted dispatches set (set wins)
  assign disp_fire    = (state == ST_DISPATCH) && disp_ready;
  assign dispatch_set = disp_fire ? (NUM_PU'(1) << pu_q) : '0;
  assign pending_left = pending_q & ~pu_done;

  // Last dispatch of a round: PU set exhausted or layer's last output row
  assign round_end    = (pu_q == PU_W'(NUM_PU - 1)) ||
                        (row_q == out_rows_q - ROW_W'(1));

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      round_q      <= '0;
      row_q        <= '0;
      pu_q         <= '0;
      out_rows_q   <= '0;
      last_round_q <= '0;
      pending_q    <= '0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      disp_valid   <= 1'b0;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
    end else begin
      pending_q  <= pending_left | dispatch_set;
      cfg_err    <= 1'b0;
      layer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              state        <= ST_DISPATCH;
              cfg_ready    <= 1'b0;
              busy         <= 1'b1;
              disp_valid   <= 1'b1;
              round_q      <= '0;
              row_q        <= '0;
              pu_q         <= '0;
              pending_q    <= '0;
              out_rows_q   <= cfg_out_rows;
              last_round_q <= ROW_W'(cfg_out_rows - ROW_W'(1)) >> PU_W;
            end
          end
        end
        ST_DISPATCH: begin
          if (disp_ready) begin
            if (round_end) begin
              state      <= ST_WAIT;
              disp_valid <= 1'b0;
            end else begin
              pu_q  <= PU_W'(pu_q + PU_W'(1));
              row_q <= ROW_W'(row_q + ROW_W'(1));
            end
          end
        end
        ST_WAIT: begin
          // Advance on the same edge that samples the last outstanding done
          if (pending_left == '0) begin
            if (round_q == last_round_q) begin
              state      <= ST_DONE;
              layer_done <= 1'b1;
            end else begin
              state      <= ST_DISPATCH;
              disp_valid <= 1'b1;
              round_q    <= ROW_W'(round_q + ROW_W'(1));
              pu_q       <= '0;
              row_q      <= ROW_W'(ROW_W'(round_q + ROW_W'(1)) << PU_W);
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign disp_pu         = pu_q;
  assign disp_row        = row_q;
  assign current_round   = round_q;
  assign current_PU1_add = ROW_W'(round_q << PU_W);
  assign current_PU_No   = ROW_W'(pu_q);
  assign current_row_No  = row_q;

endmodule

// File: tb/tb_img2col_round_sched.sv
// Self-checking bench for img2col_round_sched (NUM_PU=4, ROW_W=6).
// Table of layer configurations with hand-computed dispatch/round counts, plus
// directed sequences for done ordering, early done, spurious done and reset.
module tb_img2col_round_sched;

  localparam int unsigned NUM_PU = 4;
  localparam int unsigned ROW_W  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ROW_W-1:0]  cfg_img_rows = '0;
  logic [2:0]        cfg_kernel = '0;
  logic              cfg_err;
  logic              disp_valid;
  logic              disp_ready = 1'b1;
  logic [1:0]        disp_pu;
  logic [ROW_W-1:0]  disp_row;
  logic [NUM_PU-1:0] pu_done = '0;
  logic [ROW_W-1:0]  current_round;
  logic [ROW_W-1:0]  current_PU1_add;
  logic [ROW_W-1:0]  current_PU_No;
  logic [ROW_W-1:0]  current_row_No;
  logic              busy;
  logic              layer_done;

  int total = 0;
  int bad   = 0;

  img2col_round_sched #(.NUM_PU(NUM_PU), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_img_rows(cfg_img_rows), .cfg_kernel(cfg_kernel), .cfg_err(cfg_err),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pu(disp_pu), .disp_row(disp_row), .pu_done(pu_done),
    .current_round(current_round), .current_PU1_add(current_PU1_add),
    .current_PU_No(current_PU_No), .current_row_No(current_row_No),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int img;
    int kern;
    bit err;
    int disp;
    int rounds;
    bit toggle;
  } cfg_vec_t;

  cfg_vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_disp(input int pu, input int row);
    chk("disp_valid", int'(disp_valid), 1);
    chk("disp_pu", int'(disp_pu), pu);
    chk("disp_row", int'(disp_row), row);
  endtask

  task automatic send_cfg(input int img, input int kern);
    cfg_valid    = 1'b1;
    cfg_img_rows = ROW_W'(img);
    cfg_kernel   = 3'(kern);
    tick();
    cfg_valid    = 1'b0;
  endtask

  // Drive one layer, answer every round with one done pulse for all its PUs
  task automatic run_layer(input cfg_vec_t v);
    int k;
    int mask;
    int cyc;
    bit got_done;
    bit expect_adv;
    k = 0; mask = 0; cyc = 0; got_done = 0; expect_adv = 0;
    disp_ready = v.toggle ? 1'b0 : 1'b1;
    send_cfg(v.img, v.kern);
    if (v.err) begin
      chk("cfg_err pulse", int'(cfg_err), 1);
      chk("busy on err", int'(busy), 0);
      chk("cfg_ready on err", int'(cfg_ready), 1);
      tick();
      chk("cfg_err one cycle", int'(cfg_err), 0);
      chk("busy after err", int'(busy), 0);
    end else begin
      chk("busy after cfg", int'(busy), 1);
      chk("disp_valid after cfg", int'(disp_valid), 1);
      chk("cfg_ready after cfg", int'(cfg_ready), 0);
      chk("cfg_err on good cfg", int'(cfg_err), 0);
      while (!got_done && cyc < 2000) begin
        pu_done = '0;
        if (expect_adv) begin
          chk("advance after last done", int'(disp_valid | layer_done), 1);
          expect_adv = 0;
        end
        if (layer_done) begin
          got_done = 1;
        end else if (disp_valid) begin
          disp_ready = v.toggle ? ~disp_ready : 1'b1;
          chk("disp_pu seq", int'(disp_pu), k % 4);
          chk("disp_row seq", int'(disp_row), k);
          chk("current_row_No seq", int'(current_row_No), k);
          chk("current_PU_No seq", int'(current_PU_No), k % 4);
          chk("current_round seq", int'(current_round), k / 4);
          chk("current_PU1_add seq", int'(current_PU1_add), (k / 4) * 4);
          if (disp_ready) begin
            mask = mask | (1 << (k % 4));
            k++;
          end
        end else if (mask != 0) begin
          pu_done = NUM_PU'(mask);
          mask = 0;
          expect_adv = 1;
        end
        if (!got_done) begin
          tick();
          cyc++;
        end
      end
      pu_done = '0;
      chk("layer_done seen", int'(got_done), 1);
      chk("dispatch count", k, v.disp);
      chk("final round", int'(current_round), v.rounds - 1);
      tick();
      chk("layer_done one cycle", int'(layer_done), 0);
      chk("busy after layer", int'(busy), 0);
      chk("cfg_ready after layer", int'(cfg_ready), 1);
    end
    disp_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8,  3, 1'b0, 6,  2,  1'b0};
    vecs[1] = '{8,  0, 1'b1, 0,  0,  1'b0};
    vecs[2] = '{2,  3, 1'b1, 0,  0,  1'b0};
    vecs[3] = '{0,  1, 1'b1, 0,  0,  1'b0};
    vecs[4] = '{5,  5, 1'b0, 1,  1,  1'b0};
    vecs[5] = '{7,  4, 1'b0, 4,  1,  1'b0};
    vecs[6] = '{9,  1, 1'b0, 9,  3,  1'b0};
    vecs[7] = '{63, 7, 1'b0, 57, 15, 1'b0};
    vecs[8] = '{8,  3, 1'b0, 6,  2,  1'b1};
    vecs[9] = '{9,  1, 1'b0, 9,  3,  1'b1};

    // Reset state
    tick();
    tick();
    chk("rst cfg_ready", int'(cfg_ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst disp_valid", int'(disp_valid), 0);
    chk("rst cfg_err", int'(cfg_err), 0);
    chk("rst layer_done", int'(layer_done), 0);
    chk("rst current_round", int'(current_round), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_layer(vecs[i]);

    // Done pulses arriving out of order: 2, 0, 3, 1
    send_cfg(8, 3);
    for (int i = 0; i < 4; i++) begin
      chk_disp(i, i);
      chk("r0 current_round", int'(current_round), 0);
      tick();
    end
    chk("wait r0 disp_valid", int'(disp_valid), 0);
    chk("wait r0 busy", int'(busy), 1);
    pu_done = 4'b0100; tick();
    chk("wait after done2", int'(disp_valid), 0);
    pu_done = 4'b0001; tick();
    chk("wait after done0", int'(disp_valid), 0);
    pu_done = 4'b1000; tick();
    chk("wait after done3", int'(disp_valid), 0);
    pu_done = 4'b0010; tick();
    pu_done = 4'b0000;
    chk_disp(0, 4);
    chk("r1 current_round", int'(current_round), 1);
    chk("r1 current_PU1_add", int'(current_PU1_add), 4);
    tick();
    chk_disp(1, 5);
    tick();
    chk("wait r1 disp_valid", int'(disp_valid), 0);
    // Spurious done to a PU not dispatched this round
    pu_done = 4'b1000; tick();
    pu_done = 4'b0000;
    chk("spurious no layer_done", int'(layer_done), 0);
    chk("spurious still busy", int'(busy), 1);
    chk("spurious no dispatch", int'(disp_valid), 0);
    pu_done = 4'b0011; tick();
    pu_done = 4'b0000;
    chk("final layer_done", int'(layer_done), 1);
    chk("final busy in done", int'(busy), 1);
    chk("final cfg_ready in done", int'(cfg_ready), 0);
    tick();
    chk("post layer_done", int'(layer_done), 0);
    chk("post cfg_ready", int'(cfg_ready), 1);
    chk("post busy", int'(busy), 0);
    chk("hold current_round", int'(current_round), 1);
    chk("hold current_PU_No", int'(current_PU_No), 1);
    chk("hold current_row_No", int'(current_row_No), 5);
    chk("hold current_PU1_add", int'(current_PU1_add), 4);

    // Done for an already-dispatched PU during DISPATCH clears it at once
    send_cfg(8, 3);
    chk_disp(0, 0); tick();
    chk_disp(1, 1); pu_done = 4'b0001; tick();
    pu_done = 4'b0000;
    chk_disp(2, 2); tick();
    chk_disp(3, 3); tick();
    pu_done = 4'b1110; tick();
    pu_done = 4'b0000;
    chk_disp(0, 4);
    tick();
    chk_disp(1, 5);
    tick();
    pu_done = 4'b0011; tick();
    pu_done = 4'b0000;
    chk("early done layer_done", int'(layer_done), 1);
    tick();

    // Reset during round 1 WAIT
    send_cfg(8, 3);
    for (int i = 0; i < 4; i++) tick();
    pu_done = 4'b1111; tick();
    pu_done = 4'b0000;
    chk_disp(0, 4);
    tick();
    tick();
    chk("pre-reset wait", int'(disp_valid), 0);
    rst = 1'b1;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst disp_valid", int'(disp_valid), 0);
    chk("arst cfg_ready", int'(cfg_ready), 1);
    chk("arst current_round", int'(current_round), 0);
    chk("arst current_PU1_add", int'(current_PU1_add), 0);
    chk("arst current_row_No", int'(current_row_No), 0);
    chk("arst disp_pu", int'(disp_pu), 0);
    pu_done = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst no layer_done", int'(layer_done), 0);
      chk("arst no dispatch", int'(disp_valid), 0);
    end
    pu_done = 4'b0000;
    rst = 1'b0;
    tick();
    run_layer(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
